// File: rtl/alu_pkg.sv
// Shared types for the ALU sequencer: opcodes, FSM states, NZCV bit positions.
// Latency: n/a (declarations only). Backpressure: n/a.
// Also holds the rule for which opcodes are allowed to update C and V.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SLL = 3'd1,
        OP_SRL = 3'd2,
        OP_XOR = 3'd3,
        OP_OR  = 3'd4,
        OP_NOT = 3'd5,
        OP_AND = 3'd6,
        OP_SUB = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Only arithmetic ops produce a meaningful carry/overflow.
    function automatic logic op_sets_cv(input op_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response bus between datapath control and the ALU sequencer.
// Latency: n/a (wiring only). Backpressure: req_ready / resp_ready.
// Master = requester, slave = sequencer.
interface alu_sequencer_if #(
    parameter int WIDTH = 3
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [2:0]       req_op;
    logic             req_use_carry;
    logic             req_set_flags;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_result;
    logic [3:0]       resp_flags;

    modport master (
        output req_valid, req_a, req_b, req_op, req_use_carry, req_set_flags, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_flags
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_use_carry, req_set_flags, resp_ready,
        output req_ready, resp_valid, resp_result, resp_flags
    );
endinterface

// File: rtl/alu_flag_reg.sv
// Architectural NZCV register; N/Z always load on update, C/V only for add/sub.
// Latency: 1 cycle from update to visible flags. Backpressure: none.
// Holds its value whenever update is low.
module alu_flag_reg
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       update,
    input  op_t        op,
    input  logic [3:0] nzcv,
    output logic [3:0] flags
);

    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= 4'b0000;
        end else if (update) begin
            flags[FLAG_N] <= nzcv[FLAG_N];
            flags[FLAG_Z] <= nzcv[FLAG_Z];
            if (op_sets_cv(op)) begin
                flags[FLAG_C] <= nzcv[FLAG_C];
                flags[FLAG_V] <= nzcv[FLAG_V];
            end
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Issues one registered request to the external ALU and captures result + NZCV.
// Latency: response valid two cycles after the request is first presented; issue interval 3 cycles.
// Backpressure: req_ready low from acceptance until the response is taken; response held while resp_ready low.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    alu_sequencer_if.slave   req,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_control,
    output logic             alu_carryin,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_c,
    input  logic             alu_v,
    output logic [3:0]       flags
);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    op_t              op_q;
    logic             set_flags_q;
    logic             carryin_q;
    logic             ready_q;
    logic             resp_valid_q;
    logic [WIDTH-1:0] resp_result_q;
    logic [3:0]       resp_flags_q;
    logic [3:0]       alu_nzcv;

    assign alu_nzcv    = {alu_n, alu_z, alu_c, alu_v};
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_control = op_q;
    assign alu_carryin = carryin_q;

    assign req.req_ready   = ready_q;
    assign req.resp_valid  = resp_valid_q;
    assign req.resp_result = resp_result_q;
    assign req.resp_flags  = resp_flags_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ready_q       <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_result_q <= '0;
            resp_flags_q  <= 4'b0000;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= OP_ADD;
            set_flags_q   <= 1'b0;
            carryin_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req.req_valid) begin
                        a_q         <= req.req_a;
                        b_q         <= req.req_b;
                        op_q        <= op_t'(req.req_op);
                        set_flags_q <= req.req_set_flags;
                        // Flags cannot change before EXEC ends, so the carry-in
                        // seen during EXEC can be resolved at acceptance.
                        carryin_q   <= req.req_use_carry & flags[FLAG_C];
                        ready_q     <= 1'b0;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    resp_result_q <= alu_result;
                    resp_flags_q  <= alu_nzcv;
                    resp_valid_q  <= 1'b1;
                    carryin_q     <= 1'b0;
                    state         <= RESP;
                end
                RESP: begin
                    if (req.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        ready_q      <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    ready_q      <= 1'b1;
                    resp_valid_q <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    alu_flag_reg u_flag_reg (
        .clk    (clk),
        .rst    (rst),
        .update (state == EXEC && set_flags_q),
        .op     (op_q),
        .nzcv   (alu_nzcv),
        .flags  (flags)
    );

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: stand-in ALU, directed scenarios, then random transactions
// checked against a transaction-level model of result, NZCV and flag-register rules.
module tb_alu_sequencer;

    localparam int W    = 3;
    localparam int MASK = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_sequencer_if #(.WIDTH(W)) bus ();

    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [2:0]   alu_control;
    logic         alu_carryin, alu_n, alu_z, alu_c, alu_v;
    logic [3:0]   flags;
    logic [W+3:0] alu_out;

    int n_checks = 0;
    int n_pass   = 0;
    logic [3:0] exp_flags = 4'b0000;

    always #5 clk = ~clk;

    alu_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (bus),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_carryin (alu_carryin),
        .alu_result  (alu_result),
        .alu_n       (alu_n),
        .alu_z       (alu_z),
        .alu_c       (alu_c),
        .alu_v       (alu_v),
        .flags       (flags)
    );

    // Stand-in ALU: returns {result, N, Z, C, V}. Logic ops report C=^a, V=^b
    // so that a sequencer wrongly loading C/V on them becomes visible.
    function automatic logic [W+3:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [2:0] op, input logic cin);
        int s;
        int r;
        logic c, v, sa, sb, sr;
        sa = a[W-1];
        sb = b[W-1];
        c  = ^a;
        v  = ^b;
        case (op)
            3'd0: begin
                s = int'(a) + int'(b) + int'(cin);
                r = s & MASK;
                c = (s > MASK);
                sr = r[W-1];
                v = (sa == sb) && (sr != sa);
            end
            3'd7: begin
                s = int'(a) + (int'(~b) & MASK) + 1;
                r = s & MASK;
                c = (s > MASK);
                sr = r[W-1];
                v = (sa != sb) && (sr != sa);
            end
            3'd1: r = (int'(a) << int'(b)) & MASK;
            3'd2: r = int'(a) >> int'(b);
            3'd3: r = int'(a ^ b);
            3'd4: r = int'(a | b);
            3'd5: r = int'(~a) & MASK;
            default: r = int'(a & b);
        endcase
        return {r[W-1:0], r[W-1], (r == 0), c, v};
    endfunction

    always_comb alu_out = alu_model(alu_a, alu_b, alu_control, alu_carryin);
    assign {alu_result, alu_n, alu_z, alu_c, alu_v} = alu_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_req();
        bus.req_valid     = 1'($urandom);
        bus.req_a         = W'($urandom);
        bus.req_b         = W'($urandom);
        bus.req_op        = 3'($urandom);
        bus.req_use_carry = 1'($urandom);
        bus.req_set_flags = 1'($urandom);
    endtask

    // One full transaction; updates the flag model and returns the expected response.
    task automatic txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                       input logic uc, input logic sf, input int hold,
                       output logic [W-1:0] res, output logic [3:0] nzcv);
        logic         cin;
        logic [W+3:0] r;
        cin  = uc & exp_flags[1];
        r    = alu_model(a, b, op, cin);
        res  = r[W+3:4];
        nzcv = r[3:0];
        check("idle_req_ready", bus.req_ready, 1);
        bus.req_valid = 1'b1; bus.req_a = a; bus.req_b = b; bus.req_op = op;
        bus.req_use_carry = uc; bus.req_set_flags = sf; bus.resp_ready = 1'b0;
        tick();
        check("exec_req_ready", bus.req_ready, 0);
        check("exec_resp_valid", bus.resp_valid, 0);
        check("exec_alu_a", alu_a, a);
        check("exec_alu_b", alu_b, b);
        check("exec_alu_control", alu_control, op);
        check("exec_alu_carryin", alu_carryin, cin);
        scramble_req();
        if (sf) begin
            exp_flags[3] = nzcv[3];
            exp_flags[2] = nzcv[2];
            if (op == 3'd0 || op == 3'd7) exp_flags[1:0] = nzcv[1:0];
        end
        tick();
        for (int i = 0; i <= hold; i++) begin
            check("resp_valid", bus.resp_valid, 1);
            check("resp_req_ready", bus.req_ready, 0);
            check("resp_result", bus.resp_result, res);
            check("resp_flags", bus.resp_flags, nzcv);
            check("flags", flags, exp_flags);
            scramble_req();
            bus.resp_ready = (i == hold);
            tick();
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        check("done_resp_valid", bus.resp_valid, 0);
        check("done_req_ready", bus.req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] res;
        logic [3:0]   nzcv;
        bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_op = 3'd0;
        bus.req_use_carry = 1'b0; bus.req_set_flags = 1'b0; bus.resp_ready = 1'b0;
        rst = 1'b1;
        tick(); tick();
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_result", bus.resp_result, 0);
        check("rst_resp_flags", bus.resp_flags, 0);
        check("rst_flags", flags, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_control", alu_control, 0);
        check("rst_alu_carryin", alu_carryin, 0);
        rst = 1'b0;
        tick();

        // 3+5 wraps to 0 with carry out
        txn(3'd3, 3'd5, 3'd0, 1'b0, 1'b1, 0, res, nzcv);
        check("tp_add_result", res, 0);
        check("tp_add_flags", flags, 4'b0110);
        // 1+1+C chains the stored carry
        txn(3'd1, 3'd1, 3'd0, 1'b1, 1'b1, 0, res, nzcv);
        check("tp_adc_result", bus.resp_result, 3);
        check("tp_adc_flags", flags, 4'b0000);
        txn(3'd3, 3'd5, 3'd0, 1'b0, 1'b1, 0, res, nzcv);
        // shift keeps C=1, V=0
        txn(3'd3, 3'd1, 3'd1, 1'b0, 1'b1, 0, res, nzcv);
        check("tp_sll_result", bus.resp_result, 6);
        check("tp_sll_flags", flags, 4'b1010);
        // set_flags=0 leaves the register alone, hold response for 5 cycles
        txn(3'd5, 3'd5, 3'd3, 1'b0, 1'b0, 5, res, nzcv);
        check("tp_xor_result", bus.resp_result, 0);
        check("tp_xor_z", bus.resp_flags[2], 1);
        check("tp_xor_flags", flags, 4'b1010);

        // Reset while a sub is in EXEC discards it
        bus.req_valid = 1'b1; bus.req_a = 3'd2; bus.req_b = 3'd3; bus.req_op = 3'd7;
        bus.req_use_carry = 1'b0; bus.req_set_flags = 1'b1;
        tick();
        check("rst_exec_req_ready", bus.req_ready, 0);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_flags = 4'b0000;
        check("rst_exec_req_ready_after", bus.req_ready, 1);
        check("rst_exec_flags", flags, 0);
        for (int i = 0; i < 3; i++) begin
            check("rst_exec_no_resp", bus.resp_valid, 0);
            tick();
        end

        for (int t = 0; t < 60; t++) begin
            txn(W'($urandom), W'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)), res, nzcv);
            if ($urandom_range(0, 3) == 0) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
